// File: rtl/uart_pkg.sv
// Shared UART package: arbiter FSM state type and a small pointer helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Round-robin winner search: first set request at or above ptr, wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] index,
    output logic                     any_valid
);
    localparam int IW = $clog2(N_REQ);

    logic          found;
    int            kk;
    logic [IW-1:0] k;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        kk    = 0;
        k     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            kk = int'(ptr) + i;
            if (kk >= N_REQ) begin
                kk = kk - N_REQ;
            end
            k = IW'(kk);
            if (!found && req[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                index    = k;
            end
        end
    end

    assign any_valid = |req;

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding frames from N_REQ requesters into one UART TX FSM.
// Optional WAIT watchdog with sticky err_o when UART_ARB_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | searching for a winner; ready pulses combinationally on accept
// START | one-cycle tx_start_o to the UART TX FSM
// WAIT  | frame on the line, waiting for tx_end_i (or watchdog)
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int F_SIZE  = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [N_REQ*F_SIZE-1:0]  req_data_i,
    output logic [N_REQ-1:0]         req_ready_o,
    output logic                     tx_start_o,
    output logic [F_SIZE-1:0]        tx_data_o,
    input  logic                     tx_end_i,
    output logic                     busy_o,
`ifdef UART_ARB_TIMEOUT_EN
    output logic                     err_o,
`endif
    output logic [$clog2(N_REQ)-1:0] grant_id_o
);
    localparam int IW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("uart_tx_arb: N_REQ must be 2..8 and TIMEOUT >= 1");
    end

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     rr_ptr_q, grant_id_q;
    logic [F_SIZE-1:0] tx_data_q, sel_data;
    logic [N_REQ-1:0]  pick_grant;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic              accept;
    logic              tmo_hit;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req       (req_valid_i),
        .ptr       (rr_ptr_q),
        .grant     (pick_grant),
        .index     (pick_idx),
        .any_valid (pick_any)
    );

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick_grant[k]) begin
                sel_data = req_data_i[k*F_SIZE +: F_SIZE];
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_q;
    logic          err_q;

    // Down-counter loaded in START so the terminal count lands on the TIMEOUT-th WAIT cycle.
    assign tmo_hit = (state_q == WAIT) && (tmo_q == '0) && !tx_end_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == START) begin
                tmo_q <= TW'(TIMEOUT - 1);
            end else if (state_q == WAIT && tmo_q != '0) begin
                tmo_q <= tmo_q - 1'b1;
            end else if (state_q == IDLE) begin
                tmo_q <= '0;
            end
            if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    assign tmo_hit = 1'b0;
`endif

    // rst_n gates accept so ready stays low while reset is held.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        req_ready_o = '0;
        case (state_q)
            IDLE: begin
                if (pick_any && rst_n) begin
                    state_d     = START;
                    accept      = 1'b1;
                    req_ready_o = pick_grant;
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (tx_end_i || tmo_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            tx_data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                tx_data_q  <= sel_data;
                grant_id_q <= pick_idx;
                rr_ptr_q   <= IW'(wrap_inc(int'(pick_idx), N_REQ));
            end
        end
    end

    assign tx_start_o = (state_q == START);
    assign busy_o     = (state_q != IDLE);
    assign tx_data_o  = tx_data_q;
    assign grant_id_o = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed self-checking bench for uart_tx_arb (4 requesters, 8-bit frames, TIMEOUT=16).
module tb_uart_tx_arb;
    localparam int N  = 4;
    localparam int FS = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N*FS-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          tx_start;
    logic [FS-1:0] tx_data;
    logic          tx_end;
    logic          busy;
    logic [1:0]    grant_id;
`ifdef UART_ARB_TIMEOUT_EN
    logic          err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_arb #(.N_REQ(N), .F_SIZE(FS), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .tx_start_o  (tx_start),
        .tx_data_o   (tx_data),
        .tx_end_i    (tx_end),
        .busy_o      (busy),
`ifdef UART_ARB_TIMEOUT_EN
        .err_o       (err),
`endif
        .grant_id_o  (grant_id)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 2-3 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One full frame from IDLE with the current request pattern; winner w, data d.
    task automatic serve(input int w, input logic [7:0] d);
        #1;
        check_eq("serve_ready", 32'(req_ready), 32'(1) << w);
        check_eq("serve_idle_busy", 32'(busy), 32'd0);
        tick();
        check_eq("serve_start", 32'(tx_start), 32'd1);
        check_eq("serve_data", 32'(tx_data), 32'(d));
        check_eq("serve_gid", 32'(grant_id), 32'(w));
        check_eq("serve_start_ready", 32'(req_ready), 32'd0);
        tick();
        check_eq("serve_wait_start", 32'(tx_start), 32'd0);
        check_eq("serve_wait_ready", 32'(req_ready), 32'd0);
        tx_end = 1'b1;
        tick();
        tx_end = 1'b0;
        check_eq("serve_end_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ready"}, 32'(req_ready), 32'd0);
        check_eq({tag, "_start"}, 32'(tx_start), 32'd0);
        check_eq({tag, "_data"}, 32'(tx_data), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_gid"}, 32'(grant_id), 32'd0);
`ifdef UART_ARB_TIMEOUT_EN
        check_eq({tag, "_err"}, 32'(err), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        tx_end    = 1'b0;
        #3;
        check_all_zero("reset");
        #10 rst_n = 1'b1;
        tick();

        // Single requester 0, frame A5, several WAIT cycles before tx_end.
        req_valid = 4'b0001;
        req_data  = 32'h0000_00A5;
        #1;
        check_eq("t1_ready", 32'(req_ready), 32'h1);
        check_eq("t1_busy_idle", 32'(busy), 32'd0);
        tick();
        req_valid = '0;
        check_eq("t1_start", 32'(tx_start), 32'd1);
        check_eq("t1_data", 32'(tx_data), 32'hA5);
        check_eq("t1_busy_start", 32'(busy), 32'd1);
        tick();
        check_eq("t1_start_once", 32'(tx_start), 32'd0);
        tick();
        tick();
        check_eq("t1_busy_wait", 32'(busy), 32'd1);
        check_eq("t1_data_stable", 32'(tx_data), 32'hA5);
        tx_end = 1'b1;
        #1;
        check_eq("t1_busy_end_cycle", 32'(busy), 32'd1);
        tick();
        tx_end = 1'b0;
        check_eq("t1_busy_after", 32'(busy), 32'd0);
        check_eq("t1_data_held", 32'(tx_data), 32'hA5);

        // All four valid continuously from reset: order 0,1,2,3,0.
        rst_n = 1'b0;
        #1;
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        req_data  = 32'h1312_1110;
        for (int i = 0; i < 5; i++) begin
            serve(i % 4, 8'(8'h10 + (i % 4)));
        end

        // Pointer to 2, then 0011 wraps to 0 and then 1.
        req_valid = 4'b0010;
        serve(1, 8'h11);
        req_valid = 4'b0011;
        serve(0, 8'h10);
        serve(1, 8'h11);

        // tx_end in IDLE and START ignored.
        req_valid = '0;
        tx_end    = 1'b1;
        tick();
        tx_end = 1'b0;
        check_eq("t4_idle_end_busy", 32'(busy), 32'd0);
        req_valid = 4'b1000;
        #1;
        check_eq("t4_ready3", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        tx_end    = 1'b1;
        #1;
        check_eq("t4_start", 32'(tx_start), 32'd1);
        tick();
        tx_end = 1'b0;
        check_eq("t4_start_end_busy", 32'(busy), 32'd1);
        check_eq("t4_start_end_nostart", 32'(tx_start), 32'd0);

        // Request raised in WAIT then withdrawn before IDLE: nothing accepted.
        req_valid = 4'b0010;
        #1;
        check_eq("t4_wait_noready", 32'(req_ready), 32'd0);
        tick();
        req_valid = '0;
        tx_end    = 1'b1;
        tick();
        tx_end = 1'b0;
        #1;
        check_eq("t4_withdrawn_ready", 32'(req_ready), 32'd0);
        tick();
        check_eq("t4_withdrawn_busy", 32'(busy), 32'd0);
        check_eq("t4_withdrawn_gid", 32'(grant_id), 32'd3);

        // tx_end with a pending request in the same WAIT cycle: one IDLE cycle, then accept.
        req_valid = 4'b0100;
        #1;
        check_eq("t4_ready2", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        tick();
        req_valid = 4'b0001;
        tx_end    = 1'b1;
        #1;
        check_eq("t4_wait_hold", 32'(req_ready), 32'd0);
        tick();
        tx_end = 1'b0;
        #1;
        check_eq("t4_idle_ready0", 32'(req_ready), 32'h1);
        check_eq("t4_idle_busy", 32'(busy), 32'd0);
        tick();
        req_valid = '0;
        check_eq("t4_next_start", 32'(tx_start), 32'd1);
        check_eq("t4_next_gid", 32'(grant_id), 32'd0);
        check_eq("t4_next_data", 32'(tx_data), 32'h10);
        tick();

        // Reset while in WAIT with requester 1 pending.
        req_valid = 4'b0010;
        check_eq("t5_in_wait", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_rst");
        #1;
        rst_n     = 1'b1;
        req_valid = 4'b0011;
        #1;
        check_eq("t5_first_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check_eq("t5_first_start", 32'(tx_start), 32'd1);
        check_eq("t5_first_gid", 32'(grant_id), 32'd0);

`ifdef UART_ARB_TIMEOUT_EN
        // Watchdog: 16 WAIT cycles without tx_end force IDLE and set err.
        tick();
        tx_end = 1'b1;
        tick();
        tx_end = 1'b0;
        check_eq("t6_err_clear", 32'(err), 32'd0);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        check_eq("t6_still_wait", 32'(busy), 32'd1);
        check_eq("t6_no_err_yet", 32'(err), 32'd0);
        tick();
        check_eq("t6_timeout_idle", 32'(busy), 32'd0);
        check_eq("t6_err_set", 32'(err), 32'd1);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        tx_end = 1'b1;
        tick();
        tx_end = 1'b0;
        check_eq("t6_err_sticky", 32'(err), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_err_reset", 32'(err), 32'd0);
        rst_n = 1'b1;
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters, 2..8.
REQ-002 SHALL have parameter F_SIZE, default 8: frame data width, matching the UART TX datapath.
REQ-003 SHALL have parameter TIMEOUT, default 1023: watchdog limit in clk cycles; used only when the macro in REQ-021 is defined.
REQ-004 clk  in  1  single clock; all flops rising-edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req_valid_i  in  N_REQ  per-requester frame request.
REQ-007 req_data_i  in  N_REQ x F_SIZE  per-requester frame data, packed; requester k occupies bits [k*F_SIZE +: F_SIZE].
REQ-008 req_ready_o  in/out: out  N_REQ  one-hot, one-cycle accept pulse.
REQ-009 tx_start_o  out  1  start pulse to the UART TX FSM.
REQ-010 tx_data_o  out  F_SIZE  registered frame data to the UART TX FSM.
REQ-011 tx_end_i  in  1  end-of-frame indication (stop bit) from the UART TX FSM.
REQ-012 busy_o  out  1  high when state != IDLE.
REQ-013 grant_id_o  out  $clog2(N_REQ)  index of the current or last granted requester.

Function
REQ-014 SHALL implement FSM states IDLE, START and WAIT: IDLE->START when any req_valid_i bit is set; START->WAIT unconditionally; WAIT->IDLE on tx_end_i.
REQ-015 In IDLE, SHALL select the winner round-robin, searching upward (modulo N_REQ) from rr_ptr; rr_ptr resets to 0.
REQ-016 req_ready_o[w] SHALL be driven combinationally high in the IDLE cycle where winner w is selected, and low at all other times and for all other bits.
REQ-017 On the accept edge, SHALL register req_data_i[w] into tx_data_o, set grant_id_o to w and set rr_ptr to (w+1) mod N_REQ.
REQ-018 tx_start_o SHALL be high for exactly the one START cycle, i.e. one cycle after accept.
REQ-019 tx_data_o SHALL remain stable from the accept edge until the next accept.
REQ-020 Boundary conditions:
  - tx_end_i outside WAIT is ignored.
  - A request is never accepted in START or WAIT; requesters hold valid and data until ready.
  - Deassertion of req_valid_i before ready means nothing is accepted.
  - tx_end_i and a new request in the same WAIT cycle: go to IDLE first; the next frame is accepted the following cycle, so minimum spacing between accepts is 3 cycles.
  - A single continuous requester is served back-to-back.
  - rr_ptr wraps from N_REQ-1 to 0.

Configuration
REQ-021 With UART_ARB_TIMEOUT_EN defined:
  - A counter SHALL run while in WAIT.
  - On reaching TIMEOUT without tx_end_i, SHALL force WAIT->IDLE and set sticky output err_o (1 bit).
  - err_o is cleared only by reset.
  Without the macro, err_o and the counter SHALL not exist, and WAIT waits indefinitely.

Reset
REQ-022 While rst_n=0, SHALL hold: state=IDLE, rr_ptr=0, req_ready_o=0, tx_start_o=0, tx_data_o=0, grant_id_o=0, busy_o=0, err_o=0 and timeout counter=0.
REQ-023 Reset mid-frame SHALL abandon the frame with no replay; the first accept after release SHALL take 1 cycle from state IDLE.

Structure
REQ-024 SHALL place the state enum type (IDLE/START/WAIT) in package uart_pkg, shared with the UART TX FSM package contents.
REQ-025 SHALL place the round-robin winner search in sub-module rr_pick: inputs req and ptr; outputs one-hot grant, index and any-valid flag; purely combinational.

Verification
REQ-026 SHALL cover: req_valid_i=4'b0001, data0=8'hA5 -> req_ready_o=0001 for 1 cycle; tx_start_o high 1 cycle later; tx_data_o=8'hA5; busy_o high until 1 cycle after tx_end_i.
REQ-027 SHALL cover: all 4 requesters valid continuously from reset -> grant order 0,1,2,3,0; each accept exactly once per frame.
REQ-028 SHALL cover: rr_ptr=2 with req_valid_i=4'b0011 -> grant requester 0, then 1; wrap-around verified.
REQ-029 SHALL cover: tx_end_i pulsed in IDLE and START -> no state change; tx_end_i in WAIT with req pending -> next accept after exactly 1 IDLE cycle.
REQ-030 SHALL cover: rst_n asserted in WAIT with req 1 pending -> all outputs 0 asynchronously; after release, requester 0 wins if valid.
REQ-031 SHALL cover, with UART_ARB_TIMEOUT_EN and TIMEOUT=16: no tx_end_i -> return to IDLE after 16 WAIT cycles; err_o=1 and stays 1 until reset.
